// File: rtl/m_pkg.sv
// Shared types for the m matcher and its channel arbiter: packet word, match operands,
// arbiter state/config bundles and the round-robin pick helper.
package m_pkg;

    localparam int MAX_CH = 8;

    typedef logic [31:0] packet_type_t;

    typedef struct packed {
        logic [3:0] word;
        logic [2:0] off;
    } packet_off_t;

    typedef struct packed {
        logic        valid;
        packet_off_t off;
        logic [7:0]  symbol;
    } sym_match_t;

    typedef struct packed {
        logic        sop;
        logic        eop;
        logic [15:0] length;
        logic [63:0] data;
    } in_t;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } arb_state_t;

    typedef struct packed {
        packet_off_t          type_off;
        packet_type_t         ptype;
        sym_match_t [3:0]     sym;
    } cfg_t;

    // First requester at or above ptr, wrapping modulo n; returns 0 when nothing requests.
    function automatic logic [2:0] rr_pick(input logic [MAX_CH-1:0] req, input logic [2:0] ptr,
                                           input int n);
        logic [2:0] pick;
        logic       hit;
        int         idx;
        pick = '0;
        hit  = 1'b0;
        for (int k = 0; k < MAX_CH; k++) begin
            idx = (int'(ptr) + k) % n;
            if (k < n && !hit && req[idx[2:0]]) begin
                pick = idx[2:0];
                hit  = 1'b1;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/m_arb_cfg.sv
// Per-channel match configuration: one write port, one combinational read port.
module m_arb_cfg
    import m_pkg::*;
#(
    parameter int N_CH = 4,
    parameter int CH_W = $clog2(N_CH)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_wr_en,
    input  logic [CH_W-1:0] i_wr_ch,
    input  cfg_t            i_wr_data,
    input  logic [CH_W-1:0] i_rd_ch,
    output cfg_t            o_rd_data
);

    cfg_t r_cfg [N_CH];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N_CH; i++) r_cfg[i] <= '0;
        end else if (i_wr_en && int'(i_wr_ch) < N_CH) begin
            r_cfg[i_wr_ch] <= i_wr_data;
        end
    end

    // Reads see the pre-write value, so a write landing on a grant cycle applies to the next packet.
    assign o_rd_data = (int'(i_rd_ch) < N_CH) ? r_cfg[i_rd_ch] : '0;

endmodule

// File: rtl/m_arb.sv
// Packet-atomic round-robin arbiter feeding one shared matcher, with per-channel operands
// and a 2-cycle channel tag aligned to the matcher output.
//   state  | meaning
//   IDLE   | no packet owns the matcher; SOP words compete, stray non-SOP words are dropped
//   LOCKED | lock channel owns the matcher until its EOP transfers
module m_arb
    import m_pkg::*;
#(
    parameter int N_CH = 4,
    parameter int CH_W = $clog2(N_CH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_CH-1:0]   ch_vld_w,
    input  in_t               ch_w [N_CH],
    output logic [N_CH-1:0]   ch_rdy,
    input  logic              cfg_vld,
    input  logic [CH_W-1:0]   cfg_ch,
    input  packet_off_t       cfg_type_off,
    input  packet_type_t      cfg_type,
    input  sym_match_t [3:0]  cfg_symbol_match,
    output logic              m_in_vld_w,
    output in_t               m_in_w,
    output packet_off_t       m_packet_type_off_w,
    output packet_type_t      m_packet_type_w,
    output sym_match_t [3:0]  m_symbol_match_w,
    output logic              out_ch_vld_r,
    output logic [CH_W-1:0]   out_ch_r,
    output logic [7:0]        drop_cnt_r,
    output logic              proto_err_r
);

    arb_state_t        r_state, w_state_nxt;
    logic [CH_W-1:0]   r_rr_ptr, w_rr_nxt;
    logic [CH_W-1:0]   r_lock_ch, w_lock_nxt;
    logic              r_tag_vld;
    logic [CH_W-1:0]   r_tag_ch;
    logic [MAX_CH-1:0] w_req;
    logic [CH_W-1:0]   w_pick, w_sel;
    logic              w_drop, w_perr;
    cfg_t              w_cfg;

    function automatic logic [CH_W-1:0] inc_ch(input logic [CH_W-1:0] c);
        return (int'(c) == N_CH - 1) ? '0 : c + 1'b1;
    endfunction

    always_comb begin
        w_req = '0;
        for (int i = 0; i < N_CH; i++) w_req[i] = ch_vld_w[i] & ch_w[i].sop;
    end

    assign w_pick = CH_W'(rr_pick(w_req, 3'(r_rr_ptr), N_CH));

    always_comb begin
        ch_rdy      = '0;
        m_in_vld_w  = 1'b0;
        m_in_w      = '0;
        w_sel       = r_lock_ch;
        w_state_nxt = r_state;
        w_rr_nxt    = r_rr_ptr;
        w_lock_nxt  = r_lock_ch;
        w_drop      = 1'b0;
        w_perr      = 1'b0;
        if (!rst) begin
            case (r_state)
                IDLE: begin
                    w_sel = w_pick;
                    for (int i = 0; i < N_CH; i++) begin
                        if (ch_vld_w[i] && !ch_w[i].sop) begin
                            ch_rdy[i] = 1'b1;
                            w_drop    = 1'b1;
                        end
                    end
                    if (|w_req) begin
                        ch_rdy[w_pick] = 1'b1;
                        m_in_vld_w     = 1'b1;
                        m_in_w         = ch_w[w_pick];
                        if (ch_w[w_pick].eop) begin
                            w_rr_nxt = inc_ch(w_pick);
                        end else begin
                            w_state_nxt = LOCKED;
                            w_lock_nxt  = w_pick;
                        end
                    end
                end
                LOCKED: begin
                    ch_rdy[r_lock_ch] = 1'b1;
                    if (ch_vld_w[r_lock_ch]) begin
                        m_in_vld_w = 1'b1;
                        m_in_w     = ch_w[r_lock_ch];
                        if (ch_w[r_lock_ch].eop) begin
                            w_state_nxt = IDLE;
                            w_rr_nxt    = inc_ch(r_lock_ch);
                        end else if (ch_w[r_lock_ch].sop) begin
                            w_perr = 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    m_arb_cfg #(.N_CH(N_CH), .CH_W(CH_W)) u_cfg (
        .clk       (clk),
        .rst       (rst),
        .i_wr_en   (cfg_vld),
        .i_wr_ch   (cfg_ch),
        .i_wr_data ({cfg_type_off, cfg_type, cfg_symbol_match}),
        .i_rd_ch   (w_sel),
        .o_rd_data (w_cfg)
    );

    assign m_packet_type_off_w = w_cfg.type_off;
    assign m_packet_type_w     = w_cfg.ptype;
    assign m_symbol_match_w    = w_cfg.sym;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_rr_ptr     <= '0;
            r_lock_ch    <= '0;
            r_tag_vld    <= 1'b0;
            r_tag_ch     <= '0;
            out_ch_vld_r <= 1'b0;
            out_ch_r     <= '0;
            drop_cnt_r   <= '0;
            proto_err_r  <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_rr_ptr     <= w_rr_nxt;
            r_lock_ch    <= w_lock_nxt;
            r_tag_vld    <= m_in_vld_w;
            r_tag_ch     <= w_sel;
            out_ch_vld_r <= r_tag_vld;
            out_ch_r     <= r_tag_ch;
            if (w_drop && drop_cnt_r != 8'hFF) drop_cnt_r <= drop_cnt_r + 8'd1;
            if (w_perr) proto_err_r <= 1'b1;
        end
    end

endmodule

// File: doc/m_arb.md
# m_arb

Packet-atomic round-robin arbiter and operand scheduler for the `m` type/symbol matcher. It shares one matcher instance between `N_CH` ingress channels and holds each channel's match configuration in a per-channel register file. On every SOP word it presents the granted channel's operands, so the matcher latches the correct operands for that packet. It also emits a channel tag aligned with the matcher's egress.

## Interface
Parameters:
- `N_CH`, 4, number of ingress channels (2..8).
- `CH_W`, `$clog2(N_CH)`, channel index width.

Ports:
- `clk` in 1: the single clock.
- `rst` in 1: reset, synchronous, active-high.
- `ch_vld_w` in `N_CH`: per-channel word valid.
- `ch_w` in `m_pkg::in_t [N_CH]`: per-channel word (`sop`, `eop`, `length`, `data`).
- `ch_rdy` out `N_CH`: per-channel ready, combinational.
- `cfg_vld` in 1: configuration write strobe.
- `cfg_ch` in `CH_W`: channel being configured.
- `cfg_type_off` in `m_pkg::packet_off_t`: type offset for the channel.
- `cfg_type` in `m_pkg::packet_type_t`: type value for the channel.
- `cfg_symbol_match` in `m_pkg::sym_match_t [3:0]`: symbol entries for the channel.
- `m_in_vld_w` out 1: matcher ingress valid.
- `m_in_w` out `m_pkg::in_t`: matcher ingress word.
- `m_packet_type_off_w` out: operand to the matcher.
- `m_packet_type_w` out: operand to the matcher.
- `m_symbol_match_w` out `[3:0]`: operand to the matcher.
- `out_ch_vld_r` out 1: channel tag valid, aligned with the matcher's `out_vld_r` timing.
- `out_ch_r` out `CH_W`: channel tag.
- `drop_cnt_r` out 8: saturating count of words discarded outside a packet.
- `proto_err_r` out 1: sticky flag, set on SOP received while a packet is locked.

## Operation
- **Transfer rule.** A word transfers when `ch_vld_w[i] & ch_rdy[i]`.
  - Sources must not wait for `ch_rdy` before asserting valid.
  - `ch_rdy` may depend on `ch_vld_w`.
- **FSM `IDLE`:**
  - Candidates are channels with `ch_vld_w & ch_w.sop`.
  - Grant the first candidate at or above `rr_ptr_r`, wrapping modulo `N_CH`.
  - Set `ch_rdy[g]=1` and forward the word: `m_in_vld_w=1`, `m_in_w=ch_w[g]`, operands taken from `cfg[g]`.
  - If the word also has `eop`: stay in `IDLE` and set `rr_ptr_r=g+1` (wrap).
  - Otherwise: move to `LOCKED` with `lock_ch_r=g`.
  - Channels presenting a non-SOP valid word with no grant get `ch_rdy=1`. The word is discarded and `drop_cnt_r` increments, saturating at 255; multiple simultaneous drops count +1 per cycle.
  - All other `ch_rdy` are 0.
- **FSM `LOCKED`:**
  - `ch_rdy[lock_ch_r]=1`; all other `ch_rdy=0`.
  - Forward words from `lock_ch_r` unchanged.
  - Operands continue to be driven from `cfg[lock_ch_r]`. The matcher ignores them off-SOP.
  - On transfer with `eop`: go to `IDLE` and set `rr_ptr_r=lock_ch_r+1` (wrap).
  - On transfer with `sop` (and no eop): set `proto_err_r`, forward the word, remain `LOCKED`.
- **Config file:**
  - `cfg_vld` writes all fields of entry `cfg_ch` at the clock edge.
  - A write in the same cycle as that channel's SOP grant does not affect that packet: the old value is driven and the new value applies to the next packet.
  - `cfg_ch >= N_CH` is ignored.
- **Tag pipe:**
  - Two stages: `out_ch_vld_r`/`out_ch_r` equal `m_in_vld_w`/granted channel delayed 2 cycles.
  - This matches the matcher's input flop plus output flop.

## Timing
- Ingress-to-matcher path is combinational, with zero added latency. Tag latency is 2 cycles.
- While `rst=1`: `ch_rdy=0` and `m_in_vld_w=0`, forced combinationally.
- Reset values:
  - FSM `IDLE`, `rr_ptr_r=0`, `lock_ch_r=0`.
  - `out_ch_vld_r=0`, `out_ch_r=0`.
  - `drop_cnt_r=0`, `proto_err_r=0`.
  - All cfg entries zero, including every `symbol_match.valid=0`.
- Reset mid-packet abandons the lock. The source is responsible for restarting the packet at SOP.
- A locked channel with `ch_vld_w=0` holds the lock indefinitely; there is no timeout.
- Back-to-back packets from different channels are supported with no idle cycle: EOP in cycle t, next SOP granted in t+1.

## Structure
- Add to `m_pkg`:
  - `arb_state_t` with values `IDLE`, `LOCKED`.
  - `cfg_t` struct bundling the type offset, type and `sym_match_t [3:0]`.
  - A round-robin helper function `rr_pick(req, ptr)`.
- Natural sub-module: `m_arb_cfg`, the `N_CH`-entry config register file with write port and combinational read.
- `m_arb` instantiates `m_arb_cfg`. A wrapper, `m_top`, pairs `m_arb` with `m`.

## Test plan
- **Grant from reset:** ch0 and ch2 both present SOP (non-eop) at cycle 1 after reset → ch0 granted, `ch_rdy=4'b0001`; ch0 sends 3 words, EOP at cycle 3; ch2 granted at cycle 4; `out_ch_r=0` valid at cycle 3.
- **Round-robin fairness:** all 4 channels send continuous 1-word (sop+eop) packets → grants rotate 0,1,2,3,0 on consecutive cycles.
- **Operand capture:** `cfg[1].type=32'hDEADBEEF`, offset word 0 / off 2; ch1 SOP data with bytes [5:2]=`DEADBEEF` → the matcher receives those operands on the SOP cycle. A cfg write to ch1 on that same cycle → the next packet uses the new values.
- **Drop and saturation:** ch3 sends 300 non-SOP words while `IDLE` → all accepted, `drop_cnt_r=255`, `m_in_vld_w` stays 0.
- **Protocol error:** ch1 locked and sends a second SOP before EOP → `proto_err_r=1`, word forwarded, lock held until EOP.
- **Reset mid-packet:** `rst` asserted during ch2's 2nd word → next cycle FSM is `IDLE`, `ch_rdy=0` while `rst=1`, `out_ch_vld_r=0`, `rr_ptr_r=0`.
